// File: rtl/piso_shift_tx_pkg.sv
// piso_defs: shared state encoding and counter-width helper for the serial transmitter
package piso_defs;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 32; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/piso_shift_tx_counter.sv
// bit_down_counter: bits remaining after the current one; loads WIDTH-1, steps to zero
module bit_down_counter
    import piso_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int CW = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          zero
);
    assign zero = cnt == '0;
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (en & load) cnt <= CW'(WIDTH - 1);
        else if (en & step & ~zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: valid/ready word in, one strobed serial bit per clock out
module piso_shift_tx
    import piso_defs::*;
#(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_en,
    output logic             done,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? clog2(WIDTH) : 1;
    state_t state;
    logic [WIDTH-1:0] shreg, nxt;
    logic [CW-1:0] cnt;
    logic zero, accept, step, held;
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction
    // SHIFT with dout_en low means a stall left the current bit unconsumed
    assign held = state == ST_SHIFT & ~dout_en;
    assign din_ready = en & ~reset & (state == ST_IDLE | (zero & dout_en));
    assign accept = din_valid & din_ready;
    assign step = state == ST_SHIFT & dout_en & ~zero;
    assign nxt = MSB_FIRST ? shreg << 1 : shreg >> 1;
    assign busy = state == ST_SHIFT;
    bit_down_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk(clk), .reset(reset), .en(en), .load(accept), .step(step), .cnt(cnt), .zero(zero)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            dout <= 1'b0;
            dout_en <= 1'b0;
            done <= 1'b0;
        end else if (!en) begin
            dout_en <= 1'b0;
            done <= 1'b0;
        end else if (held) begin
            dout_en <= 1'b1;
            done <= zero;
        end else if (accept) begin
            shreg <= din;
            dout <= head(din);
            dout_en <= 1'b1;
            done <= WIDTH == 1;
            state <= ST_SHIFT;
        end else if (step) begin
            shreg <= nxt;
            dout <= head(nxt);
            done <= cnt == CW'(1);
        end else if (state == ST_SHIFT) begin
            state <= ST_IDLE;
            dout <= 1'b0;
            dout_en <= 1'b0;
            done <= 1'b0;
        end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: three builds (8/MSB, 8/LSB, 1-bit) against an index-based stream model
module tb_piso_shift_tx;
    logic clk = 1'b0, reset, en;
    logic [7:0] dv [3];
    logic [2:0] vld, rdy, so, soe, dn, bsy;
    int checks = 0, failures = 0, cyc = 0;
    int wid [3] = '{8, 8, 1};
    bit msbf [3] = '{1'b1, 1'b0, 1'b1};
    int pos [3];
    bit act [3], shw [3];
    logic [7:0] wd [3];
    logic [31:0] sbits [3], sdone [3];
    int scnt [3], sfirst [3], slast [3];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .reset(reset), .en(en), .din(dv[0]),
        .din_valid(vld[0]), .din_ready(rdy[0]), .dout(so[0]), .dout_en(soe[0]), .done(dn[0]), .busy(bsy[0]));
    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .reset(reset), .en(en), .din(dv[1]),
        .din_valid(vld[1]), .din_ready(rdy[1]), .dout(so[1]), .dout_en(soe[1]), .done(dn[1]), .busy(bsy[1]));
    piso_shift_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u2 (.clk(clk), .reset(reset), .en(en), .din(dv[2][0]),
        .din_valid(vld[2]), .din_ready(rdy[2]), .dout(so[2]), .dout_en(soe[2]), .done(dn[2]), .busy(bsy[2]));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // model: pos is the transmit-order index of the bit currently on dout
    function automatic logic mready(input int i);
        return en && !reset && (!act[i] || (pos[i] == wid[i] - 1 && shw[i]));
    endfunction
    function automatic logic mbit(input int i);
        int b;
        b = msbf[i] ? wid[i] - 1 - pos[i] : pos[i];
        return act[i] ? wd[i][b] : 1'b0;
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                act[i] = 0; shw[i] = 0; pos[i] = 0;
            end else if (!en) shw[i] = 0;
            else if (act[i] && !shw[i]) shw[i] = 1;
            else if (vld[i] && mready(i)) begin
                wd[i] = dv[i]; pos[i] = 0; act[i] = 1; shw[i] = 1;
            end else if (act[i] && pos[i] < wid[i] - 1) pos[i]++;
            else if (act[i]) begin
                act[i] = 0; shw[i] = 0;
            end
        end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dout%0d", i), so[i], mbit(i));
            chk($sformatf("dout_en%0d", i), soe[i], shw[i]);
            chk($sformatf("done%0d", i), dn[i], shw[i] && act[i] && pos[i] == wid[i] - 1);
            chk($sformatf("busy%0d", i), bsy[i], act[i]);
            chk($sformatf("ready%0d", i), rdy[i], mready(i));
            if (soe[i] && en) begin
                sbits[i] = {sbits[i][30:0], so[i]};
                sdone[i] = {sdone[i][30:0], dn[i]};
                if (scnt[i] == 0) sfirst[i] = cyc;
                slast[i] = cyc;
                scnt[i]++;
            end
        end
    end

    task automatic clr(input int i);
        sbits[i] = 0; sdone[i] = 0; scnt[i] = 0;
    endtask

    task automatic send(input int i, input logic [7:0] w);
        int n = 0;
        dv[i] = w; vld[i] = 1'b1;
        @(negedge clk);
        while (!mready(i) && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk($sformatf("send%0d_timeout", i), 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((act[i] || vld[i]) && n < 100) begin @(posedge clk); #1; n++; end
        if (n == 100) chk($sformatf("idle%0d_timeout", i), 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1; reset = 1; vld = 3'b001;
        dv[0] = 8'hA5; dv[1] = 8'h00; dv[2] = 8'h00;
        for (int i = 0; i < 3; i++) clr(i);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", rdy[0], 0); chk("rst_dout", so[0], 0); chk("rst_dout_en", soe[0], 0);
            chk("rst_busy", bsy[0], 0); chk("rst_done", dn[0], 0);
        end
        @(posedge clk); #1 reset = 0; vld = 3'b000;
        @(negedge clk); chk("post_rst_ready", rdy, 3'b111);
        @(posedge clk); #1;

        clr(0); send(0, 8'hA5); vld[0] = 0;
        @(negedge clk); chk("a5_first_bit", so[0], 1); chk("a5_first_en", soe[0], 1);
        wait_idle(0);
        chk("a5_bits", sbits[0], 32'hA5); chk("a5_done", sdone[0], 32'h01); chk("a5_cnt", scnt[0], 8);
        chk("a5_idle_en", soe[0], 0); chk("a5_idle_busy", bsy[0], 0);

        clr(1); send(1, 8'h0F); send(1, 8'hF0); vld[1] = 0; wait_idle(1);
        chk("b2b_bits", sbits[1], 32'hF00F); chk("b2b_done", sdone[1], 32'h0101);
        chk("b2b_cnt", scnt[1], 16); chk("b2b_span", slast[1] - sfirst[1] + 1, 16);

        clr(0); send(0, 8'h81); vld[0] = 0;
        repeat (3) @(posedge clk);
        #1 en = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("stall_dout_en", soe[0], 0); chk("stall_dout", so[0], 0); chk("stall_busy", bsy[0], 1);
        end
        en = 1; wait_idle(0);
        chk("stall_bits", sbits[0], 32'h81); chk("stall_done", sdone[0], 32'h01); chk("stall_cnt", scnt[0], 8);

        clr(0); send(0, 8'hFF); vld[0] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_dout", so[0], 0); chk("abort_dout_en", soe[0], 0); chk("abort_busy", bsy[0], 0);
        chk("abort_bits", sbits[0], 32'hF); chk("abort_cnt", scnt[0], 4);
        @(posedge clk); #1;
        clr(0); send(0, 8'h3C); vld[0] = 0; wait_idle(0);
        chk("after_abort_bits", sbits[0], 32'h3C); chk("after_abort_cnt", scnt[0], 8);

        clr(2); send(2, 8'h01); vld[2] = 0;
        @(negedge clk); chk("w1_dout", so[2], 1); chk("w1_dout_en", soe[2], 1); chk("w1_done", dn[2], 1);
        wait_idle(2); chk("w1_cnt", scnt[2], 1);
        clr(2); send(2, 8'h01); send(2, 8'h00); send(2, 8'h01); vld[2] = 0; wait_idle(2);
        chk("w1_b2b_bits", sbits[2], 32'h5); chk("w1_b2b_done", sdone[2], 32'h7);
        chk("w1_b2b_cnt", scnt[2], 3); chk("w1_b2b_span", slast[2] - sfirst[2] + 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
